// File: rtl/blit_fill_engine.sv
// Rectangle fill / rectangle copy engine for a 1 bpp framebuffer.
// Walks the requested rectangle one pixel per cycle (fill) or one pixel per
// two cycles (blit: read then write) against a single-port memory with a
// 1-cycle read latency. Destination pixels off screen keep their cycles but
// suppress the write strobe; off-screen source pixels read as 0.
module blit_fill_engine #(
    parameter int unsigned SCREEN_W = 320,
    parameter int unsigned SCREEN_H = 240,
    parameter int unsigned ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [8:0]        X1,
    input  logic [7:0]        Y1,
    input  logic [8:0]        X2,
    input  logic [7:0]        Y2,
    input  logic [8:0]        op_width,
    input  logic [7:0]        op_height,
    input  logic              start_blit,
    input  logic              start_fill,
    input  logic              fill_value,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic              mem_rd_data,
    output logic              mem_wr_en,
    output logic              mem_wr_data,
    output logic              busy,
    output logic              done
);

    localparam logic [9:0] ScreenWX = 10'(SCREEN_W);
    localparam logic [8:0] ScreenHY = 9'(SCREEN_H);

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StBlitRd,
        StBlitWr,
        StDone
    } state_e;

    // Linear framebuffer address; the constant multiply reduces to shift-adds.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [8:0] y, input logic [9:0] x);
        logic [31:0] full;
        full = (32'(y) * 32'(SCREEN_W)) + 32'(x);
        return full[ADDR_W-1:0];
    endfunction

    state_e     state_q, state_d;
    logic [8:0] x1_q, x1_d;
    logic [7:0] y1_q, y1_d;
    logic [8:0] x2_q, x2_d;
    logic [7:0] y2_q, y2_d;
    logic [8:0] w_q, w_d;
    logic [7:0] h_q, h_d;
    logic       fill_val_q, fill_val_d;
    logic       back_q, back_d;
    // Fill cursor holds absolute coordinates.
    logic [8:0] cx_q, cx_d;
    logic [7:0] cy_q, cy_d;
    // Blit cursor holds offsets into the rectangle.
    logic [8:0] ox_q, ox_d;
    logic [7:0] oy_q, oy_d;
    // Source pixel of the current blit step was on screen (read was issued).
    logic       rd_ok_q, rd_ok_d;

    logic [9:0] fill_x, src_x, dst_x;
    logic [8:0] fill_y, src_y, dst_y;
    logic       fill_in, src_in, dst_in;
    logic       blit_back;

    // Pixel coordinates, widened one bit so offsets never wrap.
    always_comb begin
        fill_x  = {1'b0, cx_q};
        fill_y  = {1'b0, cy_q};
        src_x   = {1'b0, x1_q} + {1'b0, ox_q};
        src_y   = {1'b0, y1_q} + {1'b0, oy_q};
        dst_x   = {1'b0, x2_q} + {1'b0, ox_q};
        dst_y   = {1'b0, y2_q} + {1'b0, oy_q};
        fill_in = (fill_x < ScreenWX) && (fill_y < ScreenHY);
        src_in  = (src_x < ScreenWX) && (src_y < ScreenHY);
        dst_in  = (dst_x < ScreenWX) && (dst_y < ScreenHY);
        // Walk backwards when the destination lies after the source in scan
        // order, so overlapping copies never read an already-written pixel.
        blit_back = (Y2 > Y1) || ((Y2 == Y1) && (X2 > X1));
    end

    // Next-state logic: operand capture, rectangle walk and termination.
    always_comb begin
        state_d    = state_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        x2_d       = x2_q;
        y2_d       = y2_q;
        w_d        = w_q;
        h_d        = h_q;
        fill_val_d = fill_val_q;
        back_d     = back_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        rd_ok_d    = rd_ok_q;

        unique case (state_q)
            StIdle: begin
                if (start_fill || start_blit) begin
                    x1_d       = X1;
                    y1_d       = Y1;
                    x2_d       = X2;
                    y2_d       = Y2;
                    w_d        = op_width;
                    h_d        = op_height;
                    fill_val_d = fill_value;
                end
                // Fill has priority; a simultaneous blit request is dropped.
                if (start_fill) begin
                    cx_d    = X1;
                    cy_d    = Y1;
                    state_d = ((X1 > X2) || (Y1 > Y2)) ? StDone : StFill;
                end else if (start_blit) begin
                    back_d = blit_back;
                    if ((op_width == 9'd0) || (op_height == 8'd0)) begin
                        state_d = StDone;
                    end else begin
                        ox_d    = blit_back ? (op_width - 9'd1) : 9'd0;
                        oy_d    = blit_back ? (op_height - 8'd1) : 8'd0;
                        state_d = StBlitRd;
                    end
                end
            end

            StFill: begin
                if (cx_q == x2_q) begin
                    if (cy_q == y2_q) begin
                        state_d = StDone;
                    end else begin
                        cx_d = x1_q;
                        cy_d = cy_q + 8'd1;
                    end
                end else begin
                    cx_d = cx_q + 9'd1;
                end
            end

            StBlitRd: begin
                rd_ok_d = src_in;
                state_d = StBlitWr;
            end

            StBlitWr: begin
                state_d = StBlitRd;
                if (back_q) begin
                    if (ox_q == 9'd0) begin
                        if (oy_q == 8'd0) begin
                            state_d = StDone;
                        end else begin
                            ox_d = w_q - 9'd1;
                            oy_d = oy_q - 8'd1;
                        end
                    end else begin
                        ox_d = ox_q - 9'd1;
                    end
                end else begin
                    if (ox_q == (w_q - 9'd1)) begin
                        if (oy_q == (h_q - 8'd1)) begin
                            state_d = StDone;
                        end else begin
                            ox_d = 9'd0;
                            oy_d = oy_q + 8'd1;
                        end
                    end else begin
                        ox_d = ox_q + 9'd1;
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decode from registered state only, so reset clears them at once.
    always_comb begin
        mem_addr    = '0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            StFill: begin
                busy        = 1'b1;
                mem_addr    = pix_addr(fill_y, fill_x);
                mem_wr_en   = fill_in;
                mem_wr_data = fill_val_q;
            end
            StBlitRd: begin
                busy      = 1'b1;
                mem_addr  = pix_addr(src_y, src_x);
                mem_rd_en = src_in;
            end
            StBlitWr: begin
                busy        = 1'b1;
                mem_addr    = pix_addr(dst_y, dst_x);
                mem_wr_en   = dst_in;
                mem_wr_data = rd_ok_q & mem_rd_data;
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            x1_q       <= '0;
            y1_q       <= '0;
            x2_q       <= '0;
            y2_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            fill_val_q <= 1'b0;
            back_q     <= 1'b0;
            cx_q       <= '0;
            cy_q       <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            rd_ok_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            x2_q       <= x2_d;
            y2_q       <= y2_d;
            w_q        <= w_d;
            h_q        <= h_d;
            fill_val_q <= fill_val_d;
            back_q     <= back_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            rd_ok_q    <= rd_ok_d;
        end
    end

endmodule

// File: tb/tb_blit_fill_engine.sv
// Scoreboard bench for blit_fill_engine: expected strobes and done pulses
// (kind, address, data, cycle offset from the start edge) are queued when an
// operation is issued and popped by a monitor on every DUT strobe.
module tb_blit_fill_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  X1, X2, op_width;
    logic [7:0]  Y1, Y2, op_height;
    logic        start_blit, start_fill, fill_value;
    logic [16:0] mem_addr;
    logic        mem_rd_en, mem_wr_en, mem_wr_data, busy, done;
    logic        mem_rd_data = 1'b0;

    blit_fill_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .X1         (X1),
        .Y1         (Y1),
        .X2         (X2),
        .Y2         (Y2),
        .op_width   (op_width),
        .op_height  (op_height),
        .start_blit (start_blit),
        .start_fill (start_fill),
        .fill_value (fill_value),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_data(mem_rd_data),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_data(mem_wr_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int op_start = 0;
    int busy_cnt = 0;
    int ma;
    assign ma = int'(mem_addr);

    always @(posedge clk) cyc <= cyc + 1;

    // Framebuffer model with 1-cycle read latency and a preload port.
    bit   fb [0:76799];
    logic pl_en = 1'b0;
    int   pl_addr = 0;
    logic pl_data = 1'b0;
    always @(posedge clk) begin
        if (pl_en) fb[pl_addr] <= pl_data;
        if (mem_rd_en) mem_rd_data <= (ma < 76800) ? fb[ma] : 1'b0;
        if (mem_wr_en && ma < 76800) fb[ma] <= mem_wr_data;
    end

    typedef struct {
        int kind;   // 0 read, 1 write, 2 done (data = busy, must be 0)
        int addr;
        int data;
        int off;
    } ev_t;
    ev_t exp_q[$];

    task automatic push(input int kind, input int addr, input int data, input int off);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.off = off;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic take(input int kind, input int addr, input int data);
        ev_t e;
        int  off;
        off = cyc - op_start + 1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d addr=%0d data=%0d off=%0d expected none",
                     kind, addr, data, off);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.addr != addr || e.data != data || e.off != off) begin
                errors++;
                $display("FAIL event: got kind=%0d addr=%0d data=%0d off=%0d expected kind=%0d addr=%0d data=%0d off=%0d",
                         kind, addr, data, off, e.kind, e.addr, e.data, e.off);
            end
        end
    endtask

    // Monitor: every strobe and done pulse must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (mem_rd_en && mem_wr_en) begin
                checks++;
                errors++;
                $display("FAIL rd_wr_exclusive: got both strobes high at addr %0d expected at most one", ma);
            end
            if (mem_rd_en) take(0, ma, 0);
            if (mem_wr_en) take(1, ma, int'(mem_wr_data));
            if (done) take(2, 0, int'(busy));
        end
    end

    task automatic start_op(input logic sf, input logic sb, input int x1, input int y1,
                            input int x2, input int y2, input int w, input int h,
                            input logic fv);
        @(negedge clk);
        X1 = 9'(x1); Y1 = 8'(y1); X2 = 9'(x2); Y2 = 8'(y2);
        op_width = 9'(w); op_height = 8'(h); fill_value = fv;
        start_fill = sf; start_blit = sb;
        op_start = cyc + 1;
        busy_cnt = 0;
        @(negedge clk);
        start_fill = 1'b0; start_blit = 1'b0;
        // Scramble operands: the engine must use its latched copies.
        X1 = 9'd0; Y1 = 8'd0; X2 = 9'd511; Y2 = 8'd255;
        op_width = 9'd7; op_height = 8'd7; fill_value = ~fv;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d events outstanding expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic preload(input int addr, input logic d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = addr; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_addr"}, ma, 0);
        chk({name, "_rd_en"}, int'(mem_rd_en), 0);
        chk({name, "_wr_en"}, int'(mem_wr_en), 0);
        chk({name, "_wr_data"}, int'(mem_wr_data), 0);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_done"}, int'(done), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        X1 = 0; Y1 = 0; X2 = 0; Y2 = 0; op_width = 0; op_height = 0;
        start_fill = 0; start_blit = 0; fill_value = 0;

        #1;
        chk_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Large fill: 71 x 61 = 4331 pixels, 12820 .. 32090, done at +4332.
        k = 1;
        for (int y = 40; y <= 100; y++)
            for (int x = 20; x <= 90; x++) begin
                push(1, y * 320 + x, 1, k);
                k++;
            end
        push(2, 0, 0, 4332);
        start_op(1'b1, 1'b0, 20, 40, 90, 100, 0, 0, 1'b1);
        drain("fill_big");
        chk("fill_big_busy", busy_cnt, 4331);

        // Overlapping blit right by 2: backward walk, snapshot semantics.
        preload(3210, 1'b1); preload(3211, 1'b0); preload(3212, 1'b1);
        preload(3213, 1'b1); preload(3214, 1'b0); preload(3215, 1'b0);
        push(0, 3213, 0, 1); push(1, 3215, 1, 2);
        push(0, 3212, 0, 3); push(1, 3214, 1, 4);
        push(0, 3211, 0, 5); push(1, 3213, 0, 6);
        push(0, 3210, 0, 7); push(1, 3212, 1, 8);
        push(2, 0, 0, 9);
        start_op(1'b0, 1'b1, 10, 10, 12, 10, 4, 1, 1'b0);
        drain("blit_overlap");
        chk("blit_busy", busy_cnt, 8);
        chk("blit_x12", int'(fb[3212]), 1);
        chk("blit_x13", int'(fb[3213]), 0);
        chk("blit_x14", int'(fb[3214]), 1);
        chk("blit_x15", int'(fb[3215]), 1);

        // Clipped fill: 21 busy cycles, writes only at x = 310..319.
        for (int x = 310; x <= 319; x++) push(1, x, 0, x - 309);
        push(2, 0, 0, 22);
        start_op(1'b1, 1'b0, 310, 0, 330, 0, 0, 0, 1'b0);
        drain("fill_clip");
        chk("fill_clip_busy", busy_cnt, 21);

        // Zero-size blit.
        push(2, 0, 0, 1);
        start_op(1'b0, 1'b1, 5, 5, 20, 20, 0, 5, 1'b0);
        drain("blit_zero");
        chk("blit_zero_busy", busy_cnt, 0);

        // Inverted fill.
        push(2, 0, 0, 1);
        start_op(1'b1, 1'b0, 50, 3, 40, 3, 0, 0, 1'b1);
        drain("fill_inv");
        chk("fill_inv_busy", busy_cnt, 0);

        // Simultaneous starts (fill wins), then a start while busy is ignored.
        for (int x = 0; x < 5; x++) push(1, 320 + x, 1, x + 1);
        push(2, 0, 0, 6);
        start_op(1'b1, 1'b1, 0, 1, 4, 1, 2, 1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        X1 = 9'd100; Y1 = 8'd5; X2 = 9'd101; Y2 = 8'd5; fill_value = 1'b1;
        start_fill = 1'b1;
        @(negedge clk);
        start_fill = 1'b0;
        drain("fill_both");
        chk("fill_both_busy", busy_cnt, 5);

        // Reset mid-way through a 100-pixel fill after 40 writes.
        for (int x = 0; x < 40; x++) push(1, 640 + x, 1, x + 1);
        start_op(1'b1, 1'b0, 0, 2, 99, 2, 0, 0, 1'b1);
        repeat (40) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("abort");
        chk("abort_queue", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        chk("abort_hold_wr_en", int'(mem_wr_en), 0);
        chk("abort_hold_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill after the abort runs normally.
        push(1, 965, 1, 1); push(1, 966, 1, 2); push(1, 967, 1, 3);
        push(2, 0, 0, 4);
        start_op(1'b1, 1'b0, 5, 3, 7, 3, 0, 0, 1'b1);
        drain("fill_after_reset");
        chk("fill_after_reset_busy", busy_cnt, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
